// File: rtl/solver_sequencer.sv
// ASCII front end for the window-compare solver. It parses newline-terminated decimal numbers,
// strobes each one into the solver, and latches the solver's final result.
module solver_sequencer #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned SETTLE = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             solver_reset,
    output logic             solver_enable,
    output logic [WIDTH-1:0] solver_value,
    input  logic [WIDTH-1:0] solver_solution,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [CNT_W-1:0] count,
    output logic             error
);

    localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [2:0] {IDLE, CLEAR, PARSE, ISSUE, FLUSH, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic             have_digit;
    logic             final_flag;
    logic [SW-1:0]    settle_cnt;

    logic [WIDTH+3:0] prod;
    logic [WIDTH-1:0] nacc;
    logic             nhd;
    logic             nerr;
    logic             is_digit;
    logic             is_nl;

    // Effect of the byte currently on in_data, assuming it transfers this cycle.
    always_comb begin
        is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
        is_nl    = (in_data == 8'h0a);
        prod     = {4'b0000, acc} * (WIDTH+4)'(10) + (WIDTH+4)'(in_data[3:0]);
        nacc     = acc;
        nhd      = have_digit;
        nerr     = error;
        if (is_digit) begin
            nhd = 1'b1;
            if (|prod[WIDTH+3:WIDTH]) begin
                nacc = '1;
                nerr = 1'b1;
            end else begin
                nacc = prod[WIDTH-1:0];
            end
        end else if (!is_nl && in_data != 8'h0d) begin
            nerr = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= IDLE;
            in_ready      <= 1'b0;
            solver_reset  <= 1'b1;
            solver_enable <= 1'b0;
            solver_value  <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            result        <= '0;
            count         <= '0;
            error         <= 1'b0;
            acc           <= '0;
            have_digit    <= 1'b0;
            final_flag    <= 1'b0;
            settle_cnt    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    solver_reset <= 1'b0;
                    if (start) begin
                        state        <= CLEAR;
                        solver_reset <= 1'b1;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        count        <= '0;
                        acc          <= '0;
                        have_digit   <= 1'b0;
                        final_flag   <= 1'b0;
                    end
                end
                CLEAR: begin
                    state        <= PARSE;
                    solver_reset <= 1'b0;
                    in_ready     <= 1'b1;
                end
                PARSE: begin
                    if (in_valid && in_ready) begin
                        acc        <= nacc;
                        have_digit <= nhd;
                        error      <= nerr;
                        // in_last with a pending number issues it first, then flushes.
                        if ((in_last && nhd) || (is_nl && nhd)) begin
                            state         <= ISSUE;
                            in_ready      <= 1'b0;
                            solver_enable <= 1'b1;
                            solver_value  <= nacc;
                            final_flag    <= in_last;
                        end else if (in_last) begin
                            state      <= FLUSH;
                            in_ready   <= 1'b0;
                            settle_cnt <= '0;
                        end
                    end
                end
                ISSUE: begin
                    solver_enable <= 1'b0;
                    acc           <= '0;
                    have_digit    <= 1'b0;
                    if (count != '1) count <= count + 1'b1;
                    if (final_flag) begin
                        state      <= FLUSH;
                        settle_cnt <= '0;
                    end else begin
                        state    <= PARSE;
                        in_ready <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (settle_cnt == SW'(SETTLE - 1)) begin
                        state  <= DONE;
                        result <= solver_solution;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_solver_sequencer.sv
// Directed bench for solver_sequencer; a small window-compare solver (x[i] > x[i-3]) answers the enables.
module tb_solver_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'h00;
    logic        in_last = 1'b0;
    logic        solver_reset;
    logic        solver_enable;
    logic [31:0] solver_value;
    logic [31:0] solver_solution;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [15:0] count;
    logic        error;

    int checks = 0;
    int failures = 0;
    int viol = 0;
    bit final_sent = 0;
    logic [31:0] issued[$];

    logic [31:0] h0, h1, h2;
    int          nval;

    always #5 clk = ~clk;

    solver_sequencer #(.WIDTH(32), .CNT_W(16), .SETTLE(1)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .solver_reset(solver_reset), .solver_enable(solver_enable),
        .solver_value(solver_value), .solver_solution(solver_solution),
        .busy(busy), .done(done), .result(result), .count(count), .error(error)
    );

    always @(posedge clk) begin
        if (solver_reset) begin
            nval <= 0;
            solver_solution <= '0;
            h0 <= '0; h1 <= '0; h2 <= '0;
        end else if (solver_enable) begin
            if (nval >= 3 && solver_value > h2) solver_solution <= solver_solution + 1;
            h2 <= h1; h1 <= h0; h0 <= solver_value;
            if (nval < 3) nval <= nval + 1;
        end
    end

    always @(negedge clk) begin
        if (reset_n && solver_enable) issued.push_back(solver_value);
        if (reset_n && solver_enable && in_ready) viol++;
        if (reset_n && final_sent && in_ready && !done) viol++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    string sample_nl;
    string sample_nonl;
    string cr;

    task automatic pulse_start();
        @(negedge clk);
        issued.delete();
        final_sent = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input string s, input bit gaps, input bit last_on_final);
        int t;
        for (int i = 0; i < s.len(); i++) begin
            if (gaps) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = s[i];
            in_last  = last_on_final && (i == s.len() - 1);
            t = 0;
            while (!in_ready && t < 100) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) begin
                checks++; failures++;
                $display("FAIL send_timeout byte %0d in_ready=%b required 1", i, in_ready);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (last_on_final) final_sent = 1;
    endtask

    task automatic wait_done();
        int t = 0;
        while (!done && t < 200) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL wait_done done=%b required 1", done);
        end
    endtask

    task automatic check_run(input string name, input logic [31:0] exp_res,
                             input logic [15:0] exp_cnt, input logic exp_err);
        checks++;
        if (result !== exp_res) begin
            failures++; $display("FAIL %s_result got %0d required %0d", name, result, exp_res);
        end
        checks++;
        if (count !== exp_cnt) begin
            failures++; $display("FAIL %s_count got %0d required %0d", name, count, exp_cnt);
        end
        checks++;
        if (error !== exp_err) begin
            failures++; $display("FAIL %s_error got %b required %b", name, error, exp_err);
        end
        checks++;
        if (issued.size() != int'(exp_cnt)) begin
            failures++; $display("FAIL %s_enables got %0d required %0d", name, issued.size(), exp_cnt);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL %s_busy got %b required 0", name, busy);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({in_ready, solver_enable, busy, done, error} !== 5'b0) begin
            failures++; $display("FAIL reset_flags got %b required 00000",
                                 {in_ready, solver_enable, busy, done, error});
        end
        checks++;
        if (solver_reset !== 1'b1) begin
            failures++; $display("FAIL reset_solver_reset got %b required 1", solver_reset);
        end
        checks++;
        if (result !== 32'd0 || count !== 16'd0 || solver_value !== 32'd0) begin
            failures++; $display("FAIL reset_values result=%0d count=%0d value=%0d required 0",
                                 result, count, solver_value);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_sample();
        logic [31:0] exp_vals[10] = '{199, 200, 208, 210, 200, 207, 240, 269, 260, 263};
        pulse_start();
        send(sample_nl, 0, 1);
        wait_done();
        check_run("sample", 32'd5, 16'd10, 1'b0);
        for (int i = 0; i < 10 && i < issued.size(); i++) begin
            checks++;
            if (issued[i] !== exp_vals[i]) begin
                failures++; $display("FAIL sample_value%0d got %0d required %0d", i, issued[i], exp_vals[i]);
            end
        end
        repeat (5) @(negedge clk);
        checks++;
        if (done !== 1'b1 || result !== 32'd5) begin
            failures++; $display("FAIL sample_hold done=%b result=%0d required 1/5", done, result);
        end
        checks++;
        if (viol != 0) begin
            failures++; $display("FAIL sample_handshake violations=%0d required 0", viol);
        end
    endtask

    task automatic test_gaps();
        viol = 0;
        pulse_start();
        send(sample_nonl, 1, 1);
        wait_done();
        check_run("gaps", 32'd5, 16'd10, 1'b0);
        checks++;
        if (issued.size() == 10 && issued[9] !== 32'd263) begin
            failures++; $display("FAIL gaps_last_value got %0d required 263", issued[9]);
        end
        checks++;
        if (viol != 0) begin
            failures++; $display("FAIL gaps_handshake violations=%0d required 0", viol);
        end
    endtask

    task automatic test_blank_lines();
        pulse_start();
        send({cr, "\n5\n\n\n6", cr, "\n"}, 0, 1);
        wait_done();
        check_run("blank", 32'd0, 16'd2, 1'b0);
        checks++;
        if (issued.size() != 2 || issued[0] !== 32'd5 || issued[1] !== 32'd6) begin
            failures++; $display("FAIL blank_values got n=%0d required 5,6", issued.size());
        end
    endtask

    task automatic test_error();
        pulse_start();
        send("12a3\n4294967296\n7\n", 0, 1);
        wait_done();
        check_run("error", 32'd0, 16'd3, 1'b1);
        checks++;
        if (issued.size() != 3 || issued[0] !== 32'd123 || issued[1] !== 32'hFFFF_FFFF
            || issued[2] !== 32'd7) begin
            failures++; $display("FAIL error_values got n=%0d required 123,FFFFFFFF,7", issued.size());
        end
        repeat (3) @(negedge clk);
        checks++;
        if (error !== 1'b1) begin
            failures++; $display("FAIL error_sticky got %b required 1", error);
        end
        pulse_start();
        checks++;
        if (error !== 1'b0) begin
            failures++; $display("FAIL error_clear got %b required 0", error);
        end
        send("\n", 0, 1);
        wait_done();
    endtask

    task automatic test_abort();
        pulse_start();
        send("199\n200\n208\n210\n", 0, 0);
        repeat (3) @(negedge clk);
        checks++;
        if (count !== 16'd4) begin
            failures++; $display("FAIL abort_precount got %0d required 4", count);
        end
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || count !== 16'd0 || solver_reset !== 1'b1) begin
            failures++; $display("FAIL abort_state busy=%b done=%b count=%0d solver_reset=%b required 0/0/0/1",
                                 busy, done, count, solver_reset);
        end
        reset_n = 1'b1;
        @(negedge clk);
        pulse_start();
        send(sample_nl, 0, 1);
        wait_done();
        check_run("abort_rerun", 32'd5, 16'd10, 1'b0);
    endtask

    task automatic test_start_ignored();
        pulse_start();
        send("199\n200\n", 0, 0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || count !== 16'd2 || solver_reset !== 1'b0) begin
            failures++; $display("FAIL start_parse busy=%b count=%0d solver_reset=%b required 1/2/0",
                                 busy, count, solver_reset);
        end
        send("208\n210\n200\n207\n240\n269\n260\n263\n", 0, 1);
        wait_done();
        check_run("start_parse", 32'd5, 16'd10, 1'b0);
        // start held two cycles in DONE: the second cycle lands in CLEAR and is ignored.
        @(negedge clk);
        issued.delete();
        final_sent = 0;
        start = 1'b1;
        @(negedge clk);
        checks++;
        if (solver_reset !== 1'b1 || done !== 1'b0 || count !== 16'd0 || busy !== 1'b1) begin
            failures++; $display("FAIL restart_clear solver_reset=%b done=%b count=%0d busy=%b required 1/0/0/1",
                                 solver_reset, done, count, busy);
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (solver_reset !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL restart_pulse solver_reset=%b in_ready=%b required 0/1",
                                 solver_reset, in_ready);
        end
        send(sample_nl, 0, 1);
        wait_done();
        check_run("restart", 32'd5, 16'd10, 1'b0);
    endtask

    initial begin
        cr = $sformatf("%c", 8'd13);
        sample_nl   = "199\n200\n208\n210\n200\n207\n240\n269\n260\n263\n";
        sample_nonl = "199\n200\n208\n210\n200\n207\n240\n269\n260\n263";
        test_reset();
        test_sample();
        test_gaps();
        test_blank_lines();
        test_error();
        test_abort();
        test_start_ignored();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
